// File: rtl/timer_irq_arbiter.sv
// -----------------------------------------------------------------------------
// timer_irq_arbiter
//   Shares the core's single interrupt input among N_SRC request sources
//   (timer strobes plus an external pin). Rising edges are captured into
//   pending flags, the lowest-index enabled request is presented on irq_o,
//   a vector byte is returned after the acknowledge, and the block stays in
//   service until the handler writes STATUS (end-of-interrupt).
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   src_i           raw request lines, synchronous to clk
//   io_sel, io_we   register access strobe / write qualifier
//   io_addr         register index: 0 ENABLE, 1 PENDING (W1C), 2 VBASE,
//                   3 STATUS (write = EOI)
//   io_wdata        write data
//   io_rdata        combinational read data for io_addr
//   irq_o           interrupt request to the core
//   inta_i          one-cycle acknowledge from the core
//   vec_o           vector byte, VBASE + 2*index
//   vec_valid_o     one-cycle qualifier for vec_o
// -----------------------------------------------------------------------------
module timer_irq_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_i,
  input  logic             io_sel,
  input  logic             io_we,
  input  logic [1:0]       io_addr,
  input  logic [7:0]       io_wdata,
  output logic [7:0]       io_rdata,
  output logic             irq_o,
  input  logic             inta_i,
  output logic [7:0]       vec_o,
  output logic             vec_valid_o
);

  localparam logic [7:0] SRC_MASK = 8'((1 << N_SRC) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VEC,
    S_SERVICE
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_en;
  logic [7:0] r_pend;
  logic [7:0] r_vbase;
  logic [7:0] r_src_prev;
  logic [2:0] r_active;

  logic [7:0] w_src8;
  logic [7:0] w_rise;
  logic [7:0] w_w1c;
  logic [7:0] w_en_eff;
  logic [7:0] w_req;
  logic [7:0] w_ack_mask;
  logic       w_wr;
  logic       w_wr_en;
  logic       w_wr_pend;
  logic       w_wr_vbase;
  logic       w_wr_eoi;
  logic       w_cand_vld;
  logic [2:0] w_cand_idx;
  logic [2:0] w_active_nxt;
  logic       w_ack;
  logic       w_busy;
  logic       w_in_service;

  // Widen the source vector to 8 bits so every register works on a byte;
  // bits at or above N_SRC stay zero.
  always_comb begin
    w_src8 = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_src8[i] = src_i[i];
    end
  end

  assign w_wr       = io_sel & io_we;
  assign w_wr_en    = w_wr & (io_addr == 2'd0);
  assign w_wr_pend  = w_wr & (io_addr == 2'd1);
  assign w_wr_vbase = w_wr & (io_addr == 2'd2);
  assign w_wr_eoi   = w_wr & (io_addr == 2'd3);

  assign w_rise = w_src8 & ~r_src_prev;
  assign w_w1c  = w_wr_pend ? (io_wdata & SRC_MASK) : '0;

  // Arbitration sees an ENABLE or PENDING write in the cycle it is sampled.
  assign w_en_eff = w_wr_en ? (io_wdata & SRC_MASK) : r_en;
  assign w_req    = r_pend & ~w_w1c & w_en_eff;

  always_comb begin
    w_cand_vld = 1'b0;
    w_cand_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!w_cand_vld && w_req[i]) begin
        w_cand_vld = 1'b1;
        w_cand_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_ack        = 1'b0;
    irq_o        = 1'b0;
    w_in_service = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cand_vld) begin
          w_state_nxt  = S_REQ;
          w_active_nxt = w_cand_idx;
        end
      end
      S_REQ: begin
        irq_o = 1'b1;
        if (inta_i) begin
          w_state_nxt = S_VEC;
          w_ack       = 1'b1;
        end else if (w_cand_vld) begin
          w_active_nxt = w_cand_idx;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_VEC: begin
        w_state_nxt = S_SERVICE;
      end
      S_SERVICE: begin
        w_in_service = 1'b1;
        if (w_wr_eoi) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_busy     = (r_state != S_IDLE);
  assign w_ack_mask = w_ack ? (8'b1 << r_active) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en        <= '0;
      r_pend      <= '0;
      r_vbase     <= '0;
      r_src_prev  <= '0;
      r_active    <= '0;
      vec_o       <= '0;
      vec_valid_o <= 1'b0;
    end else begin
      r_src_prev <= w_src8;
      r_active   <= w_active_nxt;
      // A new edge overrides both a W1C clear and the acknowledge clear.
      r_pend     <= (r_pend & ~w_w1c & ~w_ack_mask) | w_rise;
      if (w_wr_en) begin
        r_en <= io_wdata & SRC_MASK;
      end
      if (w_wr_vbase) begin
        r_vbase <= io_wdata;
      end
      if (w_ack) begin
        vec_o <= r_vbase + {4'b0000, r_active, 1'b0};
      end
      vec_valid_o <= w_ack;
    end
  end

  always_comb begin
    io_rdata = '0;
    unique case (io_addr)
      2'd0: io_rdata = r_en;
      2'd1: io_rdata = r_pend;
      2'd2: io_rdata = r_vbase;
      2'd3: io_rdata = {w_in_service, 3'b000, (w_busy ? r_active : 3'b000), w_busy};
      default: io_rdata = '0;
    endcase
  end

endmodule

// File: doc/timer_irq_arbiter.md
# timer_irq_arbiter

Interrupt arbiter and scheduler that shares the AS2650 core's single interrupt input among the timer channels and one external pin. It captures rising edges from each source into pending flags, selects the highest-priority enabled request, and drives the CPU interrupt line. It supplies a vector byte during the acknowledge handshake and holds in-service state until the handler issues end-of-interrupt. The block sits between the timer block's per-channel overflow/compare strobes and the core's `int`/`inta` pins, and is configured through the extended I/O register space.

## Interface
- `N_SRC`, 4, number of interrupt sources; index 0 has the highest priority. Legal values are 1..8.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `src_i`  in  N_SRC  raw request lines: timer strobes and the external pin, already synchronous to `clk`.
- `io_sel`  in  1  register access strobe, one cycle per access.
- `io_we`  in  1  1 = write, 0 = read; qualified by `io_sel`.
- `io_addr`  in  2  register index.
- `io_wdata`  in  8  write data.
- `io_rdata`  out  8  read data, combinational from `io_addr`.
- `irq_o`  out  1  interrupt request to the core.
- `inta_i`  in  1  acknowledge from the core, one cycle.
- `vec_o`  out  8  vector byte; valid in the cycle after `inta_i`.
- `vec_valid_o`  out  1  one-cycle qualifier for `vec_o`.

## Operation
- Registers:
  - 0 ENABLE (rw, reset 0x00): one mask bit per source.
  - 1 PENDING: reads return the flags; writing 1s clears the selected flags.
  - 2 VBASE (rw, reset 0x00).
  - 3 STATUS: reads return {in_service, 3'b0, active_idx[2:0], busy}; any write is an end-of-interrupt (EOI).
- Bits at or above N_SRC read 0 and ignore writes.
- Edge capture: `pend[i]` sets on a 0→1 transition of `src_i[i]`, measured against a registered copy of the previous value.
  - Pending flags set regardless of ENABLE.
  - If a set and a W1C clear of the same bit land in the same cycle, the set wins.
- Candidate = the lowest index i with `pend[i] & en[i]`.
- State machine:
  - IDLE: if a candidate exists, latch `active_idx` and go to REQ.
  - REQ: `irq_o` = 1. Priority is re-evaluated every cycle; a higher-priority candidate replaces `active_idx`. If the active candidate disappears (disabled or cleared) and none remains, return to IDLE.
  - REQ + `inta_i`: go to VEC and clear `pend[active_idx]`.
  - VEC (1 cycle): `vec_o` = VBASE + 2·active_idx (mod 256), `vec_valid_o` = 1, then go to SERVICE.
  - SERVICE: `irq_o` = 0 and `in_service` = 1. A write to STATUS (EOI) returns to IDLE.
  - No nesting: new requests only accumulate in PENDING.
- `inta_i` outside REQ is ignored.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: `irq_o` 0, `vec_o` 0x00, `vec_valid_o` 0, state IDLE, all registers 0. The previous-value register for `src_i` resets to 0, so a source that is high when reset releases counts as an edge on the first clock.
- Reset asserted mid-sequence returns to IDLE immediately and drops `irq_o` asynchronously.
- Latency:
  - `src_i` rising at edge k sets `pend` at k+1.
  - IDLE→REQ happens at k+2, so `irq_o` is high 2 cycles after the source edge.
  - `inta_i` sampled at edge a gives `vec_o`/`vec_valid_o` high for cycle a+1 to a+2; SERVICE starts at a+2.
  - EOI at edge e: IDLE at e+1. If anything is pending, `irq_o` rises again at e+2.
- Register writes take effect at the sampling edge; an ENABLE write is visible to arbitration in the same cycle.
- `vec_o` holds its last value outside VEC.

## Test plan
- Reset → `irq_o`=0, `vec_valid_o`=0, all four registers read 0x00.
- ENABLE=0x0F, VBASE=0x20, pulse `src_i[2]` → `irq_o` rises 2 cycles later; `inta_i` → `vec_o`=0x24 with `vec_valid_o` for 1 cycle; PENDING=0x00; STATUS=0x85; EOI → STATUS=0x00.
- Pulse `src_i[3]` and then `src_i[1]` one cycle apart, before `inta_i` → vector VBASE+2 (source 1). After EOI, `irq_o` re-asserts and the vector is VBASE+6.
- ENABLE=0x00, pulse `src_i[0]` → PENDING=0x01 and `irq_o` stays 0. Write ENABLE=0x01 → `irq_o`=1. Write PENDING=0x01 (W1C) → back to IDLE, `irq_o`=0.
- In SERVICE, pulse `src_i[0]` → `irq_o` stays 0 until EOI. VBASE=0xFE with source 1 → `vec_o`=0x00 (wrap-around).
- Assert `rst_n`=0 during REQ → `irq_o` falls without waiting for a clock edge. `inta_i` pulsed in IDLE → no `vec_valid_o`.
